seq_monitor: RTL and testbench

Downstream consumer of the 4-bit sequence counter (cycle 1000 -> 1100 -> 1101 -> 1111 -> 1000).
- Samples the counter output every enabled clock and decodes it to a phase index and a one-hot phase.
- Checks each step against the legal successor and locks after a run of correct steps.
- Counts completed sequence periods and counts errors, saturating.
- Feeds the lab display/LED stage and flags sequencing faults.

---
 rtl/seq_monitor.sv | 191 +++++++++++++++++++
 tb/tb_seq_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : seq_monitor
//  Purpose  : Watches the 4-bit sequence counter (1000->1100->1101->1111).
//             It decodes each sample to a phase, checks the sample against the
//             legal successor, and locks after LOCK_CNT consecutive good steps.
//             It also counts completed periods while locked and keeps a
//             saturating count of sequencing errors.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_monitor #(
  parameter int LOCK_CNT = 4,   // consecutive good steps needed to lock (1..15)
  parameter int CYC_W    = 8,   // period counter width
  parameter int ERR_W    = 4    // saturating error counter width
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [3:0]       seq_in,
  output logic [1:0]       phase,
  output logic [3:0]       phase_oh,
  output logic             valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CYC_W-1:0] cycles,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] C_CODE0 = 4'b1000;
  localparam logic [3:0] C_CODE1 = 4'b1100;
  localparam logic [3:0] C_CODE2 = 4'b1101;
  localparam logic [3:0] C_CODE3 = 4'b1111;

  // Returns 1 when x is one of the four codes the counter can emit.
  function automatic logic is_legal(input logic [3:0] x);
    return (x == C_CODE0) || (x == C_CODE1) || (x == C_CODE2) || (x == C_CODE3);
  endfunction

  // Returns the legal successor of x. Illegal inputs map to 1000, but they
  // never reach this function because prev is always legal outside SEARCH.
  function automatic logic [3:0] next_code(input logic [3:0] x);
    case (x)
      C_CODE0: next_code = C_CODE1;
      C_CODE1: next_code = C_CODE2;
      C_CODE2: next_code = C_CODE3;
      default: next_code = C_CODE0;
    endcase
  endfunction

  state_t           r_state, w_state_nx;
  logic [3:0]       r_prev, w_prev_nx;
  logic [3:0]       r_good, w_good_nx;
  logic [CYC_W-1:0] r_cycles, w_cycles_nx;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nx;
  logic             r_err_pulse, w_err_pulse_nx;
  logic [1:0]       r_phase, w_phase;
  logic [3:0]       r_phase_oh, w_phase_oh;
  logic             r_valid, w_valid;

  logic             w_legal;
  logic             w_step;
  logic             w_hold;
  logic             w_err_evt;
  logic [3:0]       w_good_inc;

  assign w_legal    = is_legal(seq_in);
  assign w_step     = (seq_in == next_code(r_prev));
  assign w_hold     = (seq_in == r_prev);
  assign w_good_inc = r_good + 4'd1;

  // Decode the raw sample into phase, one-hot phase and validity.
  always_comb begin
    w_valid    = 1'b0;
    w_phase    = 2'd0;
    w_phase_oh = 4'b0000;
    case (seq_in)
      C_CODE0: begin w_valid = 1'b1; w_phase = 2'd0; w_phase_oh = 4'b0001; end
      C_CODE1: begin w_valid = 1'b1; w_phase = 2'd1; w_phase_oh = 4'b0010; end
      C_CODE2: begin w_valid = 1'b1; w_phase = 2'd2; w_phase_oh = 4'b0100; end
      C_CODE3: begin w_valid = 1'b1; w_phase = 2'd3; w_phase_oh = 4'b1000; end
      default: ;
    endcase
  end

  // Next-state logic: step/hold/error classification and counter updates.
  always_comb begin
    w_state_nx     = r_state;
    w_prev_nx      = r_prev;
    w_good_nx      = r_good;
    w_cycles_nx    = r_cycles;
    w_err_cnt_nx   = r_err_cnt;
    w_err_pulse_nx = 1'b0;
    w_err_evt      = 1'b0;

    case (r_state)
      S_SEARCH: begin
        // While searching, illegal codes are ignored. The error that led
        // here has already been counted when the machine entered SEARCH.
        if (w_legal) begin
          w_prev_nx  = seq_in;
          w_good_nx  = 4'd0;
          w_state_nx = S_TRACK;
        end
      end
      S_TRACK: begin
        if (w_step) begin
          w_prev_nx = seq_in;
          w_good_nx = w_good_inc;
          if (w_good_inc == 4'(LOCK_CNT)) begin
            w_state_nx = S_LOCKED;
          end
        end else if (!w_hold) begin
          w_err_evt = 1'b1;
        end
      end
      S_LOCKED: begin
        if (w_step) begin
          w_prev_nx = seq_in;
          // A 1111 -> 1000 step closes one full period.
          if (r_prev == C_CODE3) begin
            w_cycles_nx = r_cycles + CYC_W'(1);
          end
        end else if (!w_hold) begin
          w_err_evt = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_SEARCH;
      end
    endcase

    if (w_err_evt) begin
      w_err_pulse_nx = 1'b1;
      w_good_nx      = 4'd0;
      if (r_err_cnt != {ERR_W{1'b1}}) begin
        w_err_cnt_nx = r_err_cnt + ERR_W'(1);
      end
      if (w_legal) begin
        // Resynchronise on the new legal code.
        w_prev_nx  = seq_in;
        w_state_nx = S_TRACK;
      end else begin
        w_state_nx = S_SEARCH;
      end
    end
  end

  // State and output registers. When en is low, everything holds except
  // err_pulse, which drops to zero.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_SEARCH;
      r_prev      <= 4'b0000;
      r_good      <= 4'd0;
      r_cycles    <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
      r_phase     <= 2'd0;
      r_phase_oh  <= 4'b0000;
      r_valid     <= 1'b0;
    end else if (en) begin
      r_state     <= w_state_nx;
      r_prev      <= w_prev_nx;
      r_good      <= w_good_nx;
      r_cycles    <= w_cycles_nx;
      r_err_cnt   <= w_err_cnt_nx;
      r_err_pulse <= w_err_pulse_nx;
      r_phase     <= w_phase;
      r_phase_oh  <= w_phase_oh;
      r_valid     <= w_valid;
    end else begin
      r_err_pulse <= 1'b0;
    end
  end

  assign phase     = r_phase;
  assign phase_oh  = r_phase_oh;
  assign valid     = r_valid;
  assign locked    = (r_state == S_LOCKED);
  assign err_pulse = r_err_pulse;
  assign cycles    = r_cycles;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_monitor
//  Purpose  : Self-checking bench for seq_monitor. A behavioural model
//             tracks the expected outputs and is compared against the DUT on
//             every falling edge. Literal checks pin the key scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_monitor;

  localparam int LOCK_CNT = 4;
  localparam int CYC_W    = 8;
  localparam int ERR_W    = 4;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             en  = 1'b0;
  logic [3:0]       seq_in = 4'b0000;
  logic [1:0]       phase;
  logic [3:0]       phase_oh;
  logic             valid;
  logic             locked;
  logic             err_pulse;
  logic [CYC_W-1:0] cycles;
  logic [ERR_W-1:0] err_cnt;

  seq_monitor #(.LOCK_CNT(LOCK_CNT), .CYC_W(CYC_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .clr(clr), .en(en), .seq_in(seq_in),
    .phase(phase), .phase_oh(phase_oh), .valid(valid), .locked(locked),
    .err_pulse(err_pulse), .cycles(cycles), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Behavioural model: a mode (0 search, 1 track, 2 locked), the last
  // accepted phase index, and plain integer counters.
  int m_mode, m_pidx, m_good, m_cycles, m_err, m_pulse, m_phase, m_oh, m_valid;

  function automatic int code_idx(input logic [3:0] x);
    logic [3:0] codes [4];
    codes = '{4'b1000, 4'b1100, 4'b1101, 4'b1111};
    for (int i = 0; i < 4; i++) if (codes[i] == x) return i;
    return -1;
  endfunction

  function automatic logic [3:0] idx_code(input int i);
    logic [3:0] codes [4];
    codes = '{4'b1000, 4'b1100, 4'b1101, 4'b1111};
    return codes[i % 4];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pidx = -1; m_good = 0; m_cycles = 0; m_err = 0;
    m_pulse = 0; m_phase = 0; m_oh = 0; m_valid = 0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] s);
    int i;
    if (!e) begin
      m_pulse = 0;
      return;
    end
    i = code_idx(s);
    m_valid = (i >= 0) ? 1 : 0;
    m_phase = (i >= 0) ? i : 0;
    m_oh    = (i >= 0) ? (1 << i) : 0;
    m_pulse = 0;
    if (m_mode == 0) begin
      if (i >= 0) begin m_pidx = i; m_good = 0; m_mode = 1; end
    end else if (i == m_pidx) begin
      // hold: nothing changes
    end else if (i >= 0 && i == (m_pidx + 1) % 4) begin
      if (m_mode == 2 && m_pidx == 3) m_cycles = (m_cycles + 1) % (1 << CYC_W);
      m_pidx = i;
      if (m_mode == 1) begin
        m_good++;
        if (m_good == LOCK_CNT) m_mode = 2;
      end
    end else begin
      m_pulse = 1;
      m_good  = 0;
      if (m_err < (1 << ERR_W) - 1) m_err++;
      if (i >= 0) begin m_pidx = i; m_mode = 1; end
      else m_mode = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one sample, let the edge occur, then advance the model.
  task automatic drive(input bit e, input logic [3:0] s);
    en = e;
    seq_in = s;
    @(posedge clk);
    #1;
    model_step(e, s);
  endtask

  // Pulse clr low between edges and confirm the outputs clear at once.
  task automatic async_reset();
    #1 clr = 1'b0;
    #1;
    model_reset();
    check("rst_phase",  int'(phase), 0);
    check("rst_oh",     int'(phase_oh), 0);
    check("rst_valid",  int'(valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_pulse",  int'(err_pulse), 0);
    check("rst_cycles", int'(cycles), 0);
    check("rst_errcnt", int'(err_cnt), 0);
    #1 clr = 1'b1;
  endtask

  task automatic lock_from_1000();
    drive(1, 4'b1000); drive(1, 4'b1100); drive(1, 4'b1101);
    drive(1, 4'b1111); drive(1, 4'b1000);
  endtask

  task automatic one_period();
    drive(1, 4'b1100); drive(1, 4'b1101); drive(1, 4'b1111); drive(1, 4'b1000);
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("phase",     int'(phase),     m_phase);
      check("phase_oh",  int'(phase_oh),  m_oh);
      check("valid",     int'(valid),     m_valid);
      check("locked",    int'(locked),    (m_mode == 2) ? 1 : 0);
      check("err_pulse", int'(err_pulse), m_pulse);
      check("cycles",    int'(cycles),    m_cycles);
      check("err_cnt",   int'(err_cnt),   m_err);
    end
  end

  initial begin
    int r;
    int cur;
    logic [3:0] s;
    logic [3:0] held_oh;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_locked", int'(locked), 0);
    check("init_errcnt", int'(err_cnt), 0);
    clr = 1'b1;
    chk_on = 1'b1;

    // Basic decode one edge after the first sample.
    drive(1, 4'b1000);
    check("t1_valid", int'(valid), 1);
    check("t1_oh",    int'(phase_oh), 1);

    // Lock on the fifth sample, then count periods.
    drive(1, 4'b1100); drive(1, 4'b1101); drive(1, 4'b1111);
    check("t2_notyet", int'(locked), 0);
    drive(1, 4'b1000);
    check("t2_locked", int'(locked), 1);
    check("t2_cyc0",   int'(cycles), 0);
    one_period();
    check("t2_cyc1", int'(cycles), 1);
    one_period();
    check("t2_cyc2", int'(cycles), 2);

    // Skip while locked: error, then resync from 1111.
    drive(1, 4'b1100);
    drive(1, 4'b1111);
    check("t3_pulse",  int'(err_pulse), 1);
    check("t3_errcnt", int'(err_cnt), 1);
    check("t3_unlock", int'(locked), 0);
    drive(1, 4'b1000);
    check("t3_pulse1", int'(err_pulse), 0);
    drive(1, 4'b1100); drive(1, 4'b1101); drive(1, 4'b1111);
    check("t3_relock", int'(locked), 1);

    // Illegal code while locked, followed by quiet searching.
    drive(1, 4'b0101);
    check("t4_valid",  int'(valid), 0);
    check("t4_oh",     int'(phase_oh), 0);
    check("t4_pulse",  int'(err_pulse), 1);
    check("t4_errcnt", int'(err_cnt), 2);
    repeat (3) drive(1, 4'b0101);
    check("t4_search", int'(err_cnt), 2);
    drive(1, 4'b1101);
    check("t4_track",  int'(err_cnt), 2);
    check("t4_valid2", int'(valid), 1);

    // Holds produce no error; disabled cycles change nothing.
    repeat (5) drive(1, 4'b1101);
    check("t5_hold", int'(err_cnt), 2);
    held_oh = phase_oh;
    repeat (3) drive(0, 4'b0011);
    check("t5_en_pulse", int'(err_pulse), 0);
    check("t5_en_oh",    int'(phase_oh), int'(held_oh));
    check("t5_en_oh_lit", int'(phase_oh), 4);

    // Mid-run asynchronous reset.
    async_reset();

    // Randomised traffic with a bias toward legal successors.
    cur = 0;
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      begin cur = (cur + 1) % 4; s = idx_code(cur); end
      else if (r < 80) s = idx_code(cur);
      else if (r < 90) begin cur = int'($urandom_range(0, 3)); s = idx_code(cur); end
      else             s = 4'($urandom);
      drive(($urandom_range(0, 9) != 0), s);
      if (n == 1000) async_reset();
    end

    // Error saturation: 20 separate skips.
    async_reset();
    lock_from_1000();
    cur = 0;
    for (int n = 0; n < 20; n++) begin
      cur = (cur + 2) % 4;
      drive(1, idx_code(cur));
    end
    check("t6_errsat", int'(err_cnt), 15);

    // Period counter wrap after 256 locked periods.
    async_reset();
    lock_from_1000();
    repeat (255) one_period();
    check("t6_cyc255", int'(cycles), 255);
    one_period();
    check("t6_cycwrap", int'(cycles), 0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
